// File: rtl/key_bcd_counter.sv
// key_bcd_counter: four-digit BCD event counter driven by key_control pulses.
// A key pulse selects stop / count up / count down / clear. While counting, a
// prescaler divides the clock so the counter steps once per TICK_MAX+1 clocks.
module key_bcd_counter #(
  parameter logic [25:0] TICK_MAX = 26'd49_999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        key_en,
  input  logic [3:0]  key_select,
  output logic [15:0] bcd_cnt,
  output logic [1:0]  run_state,
  output logic        tick,
  output logic        wrap
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_CLR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] presc_q, presc_d;
  logic [15:0] bcd_q, bcd_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;

  state_t      key_state;
  logic        unused_sel;

  // Only the low two selection bits carry meaning.
  assign key_state  = state_t'(key_select[1:0]);
  assign unused_sel = ^key_select[3:2];

  // Per-digit increment/decrement with a ripple carry/borrow chain; the
  // final carry/borrow out is exactly the wrap condition.
  logic [4:0]  carry_up;
  logic [4:0]  borrow_dn;
  logic [15:0] bcd_inc;
  logic [15:0] bcd_dec;

  assign carry_up[0]  = 1'b1;
  assign borrow_dn[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = bcd_q[gi*4 +: 4];
      assign bcd_inc[gi*4 +: 4] = !carry_up[gi] ? digit :
                                  (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      assign carry_up[gi+1]     = carry_up[gi] && (digit == 4'd9);
      assign bcd_dec[gi*4 +: 4] = !borrow_dn[gi] ? digit :
                                  (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      assign borrow_dn[gi+1]    = borrow_dn[gi] && (digit == 4'd0);
    end
  endgenerate

  // Next-state: a key pulse always wins (new state, prescaler restart);
  // otherwise count, hold, or leave the one-cycle clear state.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (key_en) begin
      state_d = key_state;
      presc_d = 26'd0;
      if (key_state == ST_CLR) begin
        bcd_d = 16'd0;
      end
    end else begin
      case (state_q)
        ST_UP, ST_DOWN: begin
          if (presc_q == TICK_MAX) begin
            presc_d = 26'd0;
            tick_d  = 1'b1;
            if (state_q == ST_UP) begin
              bcd_d  = bcd_inc;
              wrap_d = carry_up[4];
            end else begin
              bcd_d  = bcd_dec;
              wrap_d = borrow_dn[4];
            end
          end else begin
            presc_d = presc_q + 26'd1;
          end
        end
        ST_CLR: begin
          state_d = ST_STOP;
          presc_d = 26'd0;
        end
        default: begin
          // ST_STOP holds everything
        end
      endcase
    end
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_STOP;
      presc_q <= 26'd0;
      bcd_q   <= 16'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bcd_cnt   = bcd_q;
  assign run_state = state_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule
